decode_unit: RTL and testbench

//  RV32I decode stage; consumes fetch stage's instr/pc (IF/ID) and drives the ID/EX pipeline register.

---
 rtl/decode_unit.sv | 178 +++++++++++++++++
 tb/tb_decode_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// RV32I decode stage: register file, immediate generator, control decode and the ID/EX
// pipeline register, with load-use hazard detection against the instruction held in ID/EX.
module decode_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            stage_clk,
  input  logic            reset,
  input  logic            stage_ena,
  input  logic            flush,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic            id_funct7b5,
  output logic            id_reg_we,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic            reg_we;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
  } idex_t;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [XLEN-1:0] i);
    return $signed({{20{i[31]}}, i[31:20]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [XLEN-1:0] i);
    return $signed({{20{i[31]}}, i[31:25], i[11:7]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
    return $signed({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [XLEN-1:0] i);
    return $signed({i[31:12], 12'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
    return $signed({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
  endfunction

  logic [XLEN-1:0] regs [NREGS];
  logic [4:0]      rs1_p0, rs2_p0, rd_p0;
  logic [XLEN-1:0] rs1_data_p0, rs2_data_p0;
  logic            use_rs1_p0, use_rs2_p0, writes_rd_p0;
  idex_t           dec_p0;
  idex_t           id_p1;

  assign rs1_p0 = instr[19:15];
  assign rs2_p0 = instr[24:20];
  assign rd_p0  = instr[11:7];

  // Read ports see this cycle's writeback so a value retiring now is not lost.
  always_comb begin
    rs1_data_p0 = '0;
    rs2_data_p0 = '0;
    if (rs1_p0 != '0) rs1_data_p0 = (wb_we && wb_rd == rs1_p0) ? wb_data : regs[rs1_p0];
    if (rs2_p0 != '0) rs2_data_p0 = (wb_we && wb_rd == rs2_p0) ? wb_data : regs[rs2_p0];
  end

  // Stage p0: decode; an all-zero word is fetch's reset value and stays a bubble.
  always_comb begin
    dec_p0       = '0;
    use_rs1_p0   = 1'b0;
    use_rs2_p0   = 1'b0;
    writes_rd_p0 = 1'b0;
    if (instr != '0) begin
      dec_p0.valid    = 1'b1;
      dec_p0.pc       = pc;
      dec_p0.rs1      = rs1_p0;
      dec_p0.rs2      = rs2_p0;
      dec_p0.rd       = rd_p0;
      dec_p0.rs1_data = rs1_data_p0;
      dec_p0.rs2_data = rs2_data_p0;
      dec_p0.opcode   = instr[6:0];
      dec_p0.funct3   = instr[14:12];
      dec_p0.funct7b5 = instr[30];
      case (instr[6:0])
        OP_R:      begin writes_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; end
        OP_IMM:    begin writes_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; dec_p0.imm = imm_i(instr); end
        OP_LOAD:   begin
          writes_rd_p0    = 1'b1;
          use_rs1_p0      = 1'b1;
          dec_p0.mem_read = 1'b1;
          dec_p0.imm      = imm_i(instr);
        end
        OP_STORE:  begin
          use_rs1_p0       = 1'b1;
          use_rs2_p0       = 1'b1;
          dec_p0.mem_write = 1'b1;
          dec_p0.imm       = imm_s(instr);
        end
        OP_BRANCH: begin use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; dec_p0.imm = imm_b(instr); end
        OP_JAL:    begin writes_rd_p0 = 1'b1; dec_p0.imm = imm_j(instr); end
        OP_JALR:   begin writes_rd_p0 = 1'b1; use_rs1_p0 = 1'b1; dec_p0.imm = imm_i(instr); end
        OP_LUI,
        OP_AUIPC:  begin writes_rd_p0 = 1'b1; dec_p0.imm = imm_u(instr); end
        default:   dec_p0.illegal = 1'b1;
      endcase
      dec_p0.reg_we = writes_rd_p0 && (rd_p0 != '0);
    end
  end

  assign stall = id_p1.valid && id_p1.mem_read && (id_p1.rd != '0) && !flush &&
                 ((use_rs1_p0 && id_p1.rd == rs1_p0) || (use_rs2_p0 && id_p1.rd == rs2_p0));

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Stage p1: ID/EX register; a stall inserts a bubble while fetch holds the consumer.
  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset)              id_p1 <= '0;
    else if (flush || stall) id_p1 <= '0;
    else if (stage_ena)     id_p1 <= dec_p0;
  end

  assign id_valid     = id_p1.valid;
  assign id_illegal   = id_p1.illegal;
  assign id_reg_we    = id_p1.reg_we;
  assign id_mem_read  = id_p1.mem_read;
  assign id_mem_write = id_p1.mem_write;
  assign id_pc        = id_p1.pc;
  assign id_rs1_data  = id_p1.rs1_data;
  assign id_rs2_data  = id_p1.rs2_data;
  assign id_imm       = id_p1.imm;
  assign id_rs1       = id_p1.rs1;
  assign id_rs2       = id_p1.rs2;
  assign id_rd        = id_p1.rd;
  assign id_opcode    = id_p1.opcode;
  assign id_funct3    = id_p1.funct3;
  assign id_funct7b5  = id_p1.funct7b5;

endmodule

// File: tb/tb_decode_unit.sv
// Testbench for decode_unit: directed scenarios plus randomized traffic against an
// architectural model of the register file and the ID/EX slot.
module tb_decode_unit;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011,
                         ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111,
                         JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, AUIPC_OP = 7'b0010111;

  logic        stage_clk = 1'b0;
  logic        reset, stage_ena, flush, wb_we;
  logic [31:0] instr, pc, wb_data;
  logic [4:0]  wb_rd;
  logic        stall, id_valid, id_funct7b5, id_reg_we, id_mem_read, id_mem_write, id_illegal;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;

  decode_unit dut (
    .stage_clk(stage_clk), .reset(reset), .stage_ena(stage_ena), .flush(flush),
    .instr(instr), .pc(pc), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_reg_we(id_reg_we), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_illegal(id_illegal)
  );

  always #5 stage_clk = ~stage_clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [158:0] all_id;
  assign all_id = {id_valid, id_illegal, id_reg_we, id_mem_read, id_mem_write, id_pc,
                   id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_opcode,
                   id_funct3, id_funct7b5};

  // Architectural model: register values and the instruction currently in EX.
  logic [31:0] mregs [32];
  logic        m_valid, m_illegal, m_reg_we, m_mem_read, m_mem_write, m_f7;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        exp_stall, smp_stall;

  function automatic logic [158:0] model_all();
    return {m_valid, m_illegal, m_reg_we, m_mem_read, m_mem_write, m_pc, m_rs1d, m_rs2d,
            m_imm, m_rs1, m_rs2, m_rd, m_op, m_f3, m_f7};
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    logic [31:0] v;
    case (i[6:0])
      I_OP, LD_OP, JALR_OP: v = {{20{i[31]}}, i[31:20]};
      ST_OP:                v = {{20{i[31]}}, i[31:25], i[11:7]};
      BR_OP:                v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      LUI_OP, AUIPC_OP:     v = {i[31:12], 12'b0};
      JAL_OP:               v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:              v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic model_stall(input logic [31:0] i, input logic fl);
    logic r1, r2;
    r1 = i[6:0] inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JALR_OP};
    r2 = i[6:0] inside {R_OP, ST_OP, BR_OP};
    if (fl || !m_valid || !m_mem_read || m_rd == 5'd0) return 1'b0;
    return (r1 && i[19:15] == m_rd) || (r2 && i[24:20] == m_rd);
  endfunction

  task automatic model_bubble();
    {m_valid, m_illegal, m_reg_we, m_mem_read, m_mem_write, m_pc, m_rs1d, m_rs2d,
     m_imm, m_rs1, m_rs2, m_rd, m_op, m_f3, m_f7} = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    model_bubble();
  endtask

  task automatic model_load(input logic [31:0] i, input logic [31:0] p);
    if (i == 32'h0) begin
      model_bubble();
    end else begin
      m_valid     = 1'b1;
      m_illegal   = !(i[6:0] inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP,
                                     LUI_OP, AUIPC_OP});
      m_mem_read  = (i[6:0] == LD_OP);
      m_mem_write = (i[6:0] == ST_OP);
      m_reg_we    = (i[6:0] inside {R_OP, I_OP, LD_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP})
                    && (i[11:7] != 5'd0);
      m_pc  = p;
      m_rs1 = i[19:15];
      m_rs2 = i[24:20];
      m_rd  = i[11:7];
      m_rs1d = mregs[m_rs1];
      m_rs2d = mregs[m_rs2];
      m_imm = model_imm(i);
      m_op  = i[6:0];
      m_f3  = i[14:12];
      m_f7  = i[30];
    end
  endtask

  // One clock: drive at the falling edge, sample stall, update model at the rising edge.
  task automatic cyc(input logic [31:0] i, input logic [31:0] p, input logic fl,
                     input logic ena, input logic we, input logic [4:0] rd,
                     input logic [31:0] d);
    instr = i; pc = p; flush = fl; stage_ena = ena; wb_we = we; wb_rd = rd; wb_data = d;
    #1;
    smp_stall = stall;
    exp_stall = model_stall(i, fl);
    @(posedge stage_clk);
    if (we && rd != 5'd0) mregs[rd] = d;
    if (fl || exp_stall) model_bubble();
    else if (ena) model_load(i, p);
    @(negedge stage_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; stage_ena = 1'b1; flush = 1'b0; instr = 32'h00500093; pc = 32'h40;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    model_reset();
    repeat (2) @(posedge stage_clk);
    @(negedge stage_clk);
    n_checks++;
    if (all_id !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", all_id);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    cyc(32'h00500093, 32'h100, 0, 1, 0, 0, 0);
    n_checks++;
    if ({id_valid, id_reg_we, id_rd, id_imm, id_rs1_data} !== {1'b1, 1'b1, 5'd1, 32'd5, 32'd0}) begin
      n_err++;
      $display("FAIL addi: got v=%b we=%b rd=%0d imm=%h rs1d=%h want v=1 we=1 rd=1 imm=5 rs1d=0",
               id_valid, id_reg_we, id_rd, id_imm, id_rs1_data);
    end
  endtask

  task automatic test_load_use();
    cyc(32'h0000A103, 32'h104, 0, 1, 0, 0, 0);
    n_checks++;
    if ({id_mem_read, id_rd, id_reg_we} !== {1'b1, 5'd2, 1'b1}) begin
      n_err++; $display("FAIL lw_decode: got mr=%b rd=%0d we=%b want mr=1 rd=2 we=1",
                        id_mem_read, id_rd, id_reg_we);
    end
    cyc(32'h002101B3, 32'h108, 0, 1, 0, 0, 0);
    n_checks++;
    if (smp_stall !== 1'b1) begin
      n_err++; $display("FAIL load_use_stall: got %b want 1", smp_stall);
    end
    n_checks++;
    if (all_id !== '0) begin
      n_err++; $display("FAIL load_use_bubble: got %h want 0", all_id);
    end
    cyc(32'h002101B3, 32'h108, 0, 1, 0, 0, 0);
    n_checks++;
    if (smp_stall !== 1'b0) begin
      n_err++; $display("FAIL stall_clears: got %b want 0", smp_stall);
    end
    n_checks++;
    if ({id_valid, id_rd, id_rs1, id_rs2, id_pc} !== {1'b1, 5'd3, 5'd2, 5'd2, 32'h108}) begin
      n_err++; $display("FAIL add_after_stall: got v=%b rd=%0d rs1=%0d rs2=%0d pc=%h want 1 3 2 2 108",
                        id_valid, id_rd, id_rs1, id_rs2, id_pc);
    end
  endtask

  task automatic test_bypass();
    cyc(32'h00018233, 32'h10C, 0, 1, 1, 5'd3, 32'hDEADBEEF);
    n_checks++;
    if ({id_rs1_data, id_rs2_data} !== {32'hDEADBEEF, 32'h0}) begin
      n_err++; $display("FAIL wb_bypass: got rs1d=%h rs2d=%h want deadbeef 0", id_rs1_data, id_rs2_data);
    end
    cyc(32'h00018233, 32'h110, 0, 1, 0, 0, 0);
    n_checks++;
    if (id_rs1_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL regfile_keep: got %h want deadbeef", id_rs1_data);
    end
  endtask

  task automatic test_x0();
    cyc(32'h00000233, 32'h114, 0, 1, 1, 5'd0, 32'h1234);
    n_checks++;
    if ({id_rs1_data, id_rs2_data} !== 64'h0) begin
      n_err++; $display("FAIL x0_write_bypass: got %h %h want 0 0", id_rs1_data, id_rs2_data);
    end
    cyc(32'hFE000CE3, 32'h118, 0, 1, 0, 0, 0);
    n_checks++;
    if ({id_imm, id_valid, id_reg_we} !== {32'hFFFFFFF8, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL beq_imm: got imm=%h v=%b we=%b want fffffff8 1 0", id_imm, id_valid, id_reg_we);
    end
  endtask

  task automatic test_flush();
    cyc(32'h002101B3, 32'h11C, 1, 1, 0, 0, 0);
    n_checks++;
    if ({id_valid, id_reg_we} !== 2'b00) begin
      n_err++; $display("FAIL flush_bubble: got v=%b we=%b want 0 0", id_valid, id_reg_we);
    end
    cyc(32'h0000A103, 32'h120, 0, 1, 0, 0, 0);
    cyc(32'h002101B3, 32'h124, 1, 1, 0, 0, 0);
    n_checks++;
    if ({smp_stall, id_valid} !== 2'b00) begin
      n_err++; $display("FAIL flush_beats_stall: got stall=%b v=%b want 0 0", smp_stall, id_valid);
    end
  endtask

  task automatic test_hold();
    cyc(32'h00500093, 32'h200, 0, 1, 0, 0, 0);
    cyc(32'h00A00113, 32'h204, 0, 0, 0, 0, 0);
    n_checks++;
    if ({id_rd, id_imm, id_pc} !== {5'd1, 32'd5, 32'h200}) begin
      n_err++; $display("FAIL ena_hold: got rd=%0d imm=%h pc=%h want 1 5 200", id_rd, id_imm, id_pc);
    end
    cyc(32'h00A00113, 32'h204, 1, 0, 0, 0, 0);
    n_checks++;
    if (id_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_when_held: got v=%b want 0", id_valid);
    end
    cyc(32'h00000000, 32'h208, 0, 1, 0, 0, 0);
    n_checks++;
    if (all_id !== '0) begin
      n_err++; $display("FAIL zero_instr_bubble: got %h want 0", all_id);
    end
  endtask

  task automatic test_reset_mid();
    cyc(32'h00500093, 32'h300, 0, 1, 1, 5'd1, 32'h55);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({all_id, stall} !== '0) begin
      n_err++; $display("FAIL async_reset: got %h stall=%b want 0", all_id, stall);
    end
    @(posedge stage_clk);
    @(negedge stage_clk);
    reset = 1'b0;
    model_reset();
    cyc(32'h000082B3, 32'h304, 0, 1, 0, 0, 0);
    n_checks++;
    if ({id_rs1, id_rs1_data} !== {5'd1, 32'h0}) begin
      n_err++; $display("FAIL x1_after_reset: got rs1=%0d data=%h want 1 0", id_rs1, id_rs1_data);
    end
    cyc(32'h0000007F, 32'h308, 0, 1, 0, 0, 0);
    n_checks++;
    if ({id_valid, id_illegal, id_reg_we, id_mem_read, id_mem_write, id_opcode} !==
        {5'b11000, 7'h7F}) begin
      n_err++; $display("FAIL illegal_op: got v=%b il=%b we=%b mr=%b mw=%b op=%h want 1 1 0 0 0 7f",
                        id_valid, id_illegal, id_reg_we, id_mem_read, id_mem_write, id_opcode);
    end
  endtask

  task automatic test_random();
    logic [31:0] ri, rp;
    ri = 32'h0; rp = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      if (!(n > 0 && smp_stall)) begin
        ri = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          ri[19:15] = 5'($urandom_range(0, 3));
          ri[24:20] = 5'($urandom_range(0, 3));
          ri[11:7]  = 5'($urandom_range(0, 3));
        end
        case ($urandom_range(0, 11))
          0: ri[6:0] = R_OP;    1: ri[6:0] = I_OP;     2: ri[6:0] = LD_OP;
          3: ri[6:0] = ST_OP;   4: ri[6:0] = BR_OP;    5: ri[6:0] = JAL_OP;
          6: ri[6:0] = JALR_OP; 7: ri[6:0] = LUI_OP;   8: ri[6:0] = AUIPC_OP;
          9: ri = 32'h0;        10: ri[6:0] = LD_OP;   default: ;
        endcase
        rp = rp + 32'd4;
      end
      cyc(ri, rp, $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      n_checks++;
      if (smp_stall !== exp_stall) begin
        n_err++; $display("FAIL rand_stall[%0d]: got %b want %b instr=%h", n, smp_stall, exp_stall, ri);
      end
      n_checks++;
      if (all_id !== model_all()) begin
        n_err++; $display("FAIL rand_idex[%0d]: got %h want %h instr=%h", n, all_id, model_all(), ri);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_x0();
    test_flush();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
